// File: rtl/riscv_selfcheck_monitor_if.sv
// Bus bundle between a single-cycle core bench and its pass/fail monitor.
// The master drives the snooped core signals; the monitor (slave) returns the verdict.
interface riscv_selfcheck_monitor_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CW   = 6
);
  logic            enable;
  logic [XLEN-1:0] pc;
  logic            rd_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_wdata;

  logic            done;
  logic            pass;
  logic            fail;
  logic            timeout;
  logic [XLEN-1:0] fail_pc;
  logic [XLEN-1:0] fail_data;
  logic [CW-1:0]   cycle_count;

  modport master (
    output enable, pc, rd_we, rd_addr, rd_wdata,
    input  done, pass, fail, timeout, fail_pc, fail_data, cycle_count
  );

  modport slave (
    input  enable, pc, rd_we, rd_addr, rd_wdata,
    output done, pass, fail, timeout, fail_pc, fail_data, cycle_count
  );
endinterface

// File: rtl/riscv_selfcheck_monitor.sv
// Pass/fail monitor for a single-cycle RISC-V core. Watches one probe register for
// illegal writes and ends the run on PC out of range, a PC self-loop or a cycle budget.
// The verdict is sticky until enable drops or reset is asserted.
module riscv_selfcheck_monitor #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     PROBE_REG       = 31,
  parameter logic [XLEN-1:0] EXPECT          = '0,
  parameter int unsigned     PROG_WORDS      = 32,
  parameter int unsigned     HALT_REPEAT     = 2,
  parameter int unsigned     MAX_CYCLES      = 32,
  parameter bit              TIMEOUT_IS_FAIL = 1'b0,
  parameter int unsigned     CW              = $clog2(MAX_CYCLES + 1)
) (
  input logic                    clk,
  input logic                    reset,
  riscv_selfcheck_monitor_if.slave mon
);

  localparam int unsigned     RW        = $clog2(HALT_REPEAT + 1);
  localparam logic [XLEN-1:0] PcEnd     = XLEN'(PROG_WORDS * 4);
  localparam logic [4:0]      ProbeAddr = 5'(PROBE_REG);
  localparam logic [CW-1:0]   MaxCnt    = CW'(MAX_CYCLES);
  localparam logic [RW-1:0]   HaltCnt   = RW'(HALT_REPEAT);

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cycle_q, cycle_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic [XLEN-1:0] prev_pc_q, prev_pc_d;
  logic            prev_valid_q, prev_valid_d;
  logic            timeout_q, timeout_d;
  logic [XLEN-1:0] fail_pc_q, fail_pc_d;
  logic [XLEN-1:0] fail_data_q, fail_data_d;

  logic            probe_bad;
  logic            out_of_range;
  logic            same_pc;
  logic [CW-1:0]   cycle_inc;
  logic [RW-1:0]   rep_inc;

  // x0 can never be the probe, even if the parameter is misconfigured to 0.
  assign probe_bad    = mon.rd_we && (mon.rd_addr == ProbeAddr) && (mon.rd_addr != 5'd0) &&
                        (mon.rd_wdata != EXPECT);
  assign out_of_range = (mon.pc >= PcEnd);
  assign same_pc      = prev_valid_q && (mon.pc == prev_pc_q);
  assign cycle_inc    = cycle_q + CW'(1);
  assign rep_inc      = rep_q + RW'(1);

  // Next-state: enable gates everything, then run checks in priority order.
  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    rep_d        = rep_q;
    prev_pc_d    = prev_pc_q;
    prev_valid_d = prev_valid_q;
    timeout_d    = timeout_q;
    fail_pc_d    = fail_pc_q;
    fail_data_d  = fail_data_q;

    if (!mon.enable) begin
      state_d      = StIdle;
      cycle_d      = '0;
      rep_d        = '0;
      prev_pc_d    = '0;
      prev_valid_d = 1'b0;
      timeout_d    = 1'b0;
      fail_pc_d    = '0;
      fail_data_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Start edge only arms the run; nothing is sampled yet.
          state_d      = StRun;
          cycle_d      = '0;
          rep_d        = '0;
          prev_valid_d = 1'b0;
          timeout_d    = 1'b0;
          fail_pc_d    = '0;
          fail_data_d  = '0;
        end
        StRun: begin
          cycle_d      = cycle_inc;
          prev_pc_d    = mon.pc;
          prev_valid_d = 1'b1;
          rep_d        = same_pc ? rep_inc : '0;
          if (probe_bad) begin
            state_d     = StFail;
            fail_pc_d   = mon.pc;
            fail_data_d = mon.rd_wdata;
          end else if (out_of_range) begin
            state_d = StPass;
          end else if (same_pc && (rep_inc == HaltCnt)) begin
            state_d = StPass;
          end else if (cycle_inc == MaxCnt) begin
            timeout_d = 1'b1;
            state_d   = TIMEOUT_IS_FAIL ? StFail : StPass;
          end
        end
        default: ; // verdict states hold until enable drops
      endcase
    end
  end

  // State and capture registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cycle_q      <= '0;
      rep_q        <= '0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      fail_pc_q    <= '0;
      fail_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      rep_q        <= rep_d;
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
      timeout_q    <= timeout_d;
      fail_pc_q    <= fail_pc_d;
      fail_data_q  <= fail_data_d;
    end
  end

  assign mon.done        = (state_q == StPass) || (state_q == StFail);
  assign mon.pass        = (state_q == StPass);
  assign mon.fail        = (state_q == StFail);
  assign mon.timeout     = timeout_q;
  assign mon.fail_pc     = fail_pc_q;
  assign mon.fail_data   = fail_data_q;
  assign mon.cycle_count = cycle_q;

endmodule

// File: tb/tb_riscv_selfcheck_monitor.sv
// Bench for riscv_selfcheck_monitor: two differently parametrised monitors driven by the
// same core-bus stimulus, each compared against a behavioural model of the run rules.
module tb_riscv_selfcheck_monitor;

  logic clk;
  logic reset;

  riscv_selfcheck_monitor_if #(.XLEN(32), .CW(6)) if0 ();
  riscv_selfcheck_monitor_if #(.XLEN(32), .CW(3)) if1 ();

  riscv_selfcheck_monitor #(
    .XLEN(32), .PROBE_REG(31), .EXPECT(32'h0), .PROG_WORDS(32), .HALT_REPEAT(2),
    .MAX_CYCLES(32), .TIMEOUT_IS_FAIL(1'b0)
  ) dut0 (
    .clk  (clk),
    .reset(reset),
    .mon  (if0)
  );

  riscv_selfcheck_monitor #(
    .XLEN(32), .PROBE_REG(5), .EXPECT(32'hA5), .PROG_WORDS(8), .HALT_REPEAT(1),
    .MAX_CYCLES(4), .TIMEOUT_IS_FAIL(1'b1)
  ) dut1 (
    .clk  (clk),
    .reset(reset),
    .mon  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Parameters of the two instances, as seen by the model.
  int unsigned p_pw   [2] = '{32, 8};
  int unsigned p_hr   [2] = '{2, 1};
  int unsigned p_max  [2] = '{32, 4};
  bit          p_tif  [2] = '{1'b0, 1'b1};
  logic [4:0]  p_probe[2] = '{5'd31, 5'd5};
  logic [31:0] p_exp  [2] = '{32'h0, 32'hA5};

  // Model: phase 0 idle, 1 running, 2 passed, 3 failed.
  int          m_phase [2];
  int unsigned m_cnt   [2];
  bit          m_to    [2];
  logic [31:0] m_fpc   [2];
  logic [31:0] m_fdata [2];
  logic [31:0] m_last  [2];
  bit          m_have  [2];
  int unsigned m_streak[2];

  int vectors;
  int miscompares;

  function automatic void model_clear(int k);
    m_phase[k]  = 0;
    m_cnt[k]    = 0;
    m_to[k]     = 1'b0;
    m_fpc[k]    = '0;
    m_fdata[k]  = '0;
    m_last[k]   = '0;
    m_have[k]   = 1'b0;
    m_streak[k] = 0;
  endfunction

  function automatic void model_edge(int k, logic en, logic [31:0] p, logic we, logic [4:0] a,
                                     logic [31:0] d);
    bit same;
    if (!en) begin
      model_clear(k);
      return;
    end
    case (m_phase[k])
      0: begin
        model_clear(k);
        m_phase[k] = 1;
      end
      1: begin
        m_cnt[k]    = m_cnt[k] + 1;
        same        = m_have[k] && (p == m_last[k]);
        m_streak[k] = same ? m_streak[k] + 1 : 0;
        m_last[k]   = p;
        m_have[k]   = 1'b1;
        if (we && a != 5'd0 && a == p_probe[k] && d != p_exp[k]) begin
          m_phase[k] = 3;
          m_fpc[k]   = p;
          m_fdata[k] = d;
        end else if (p >= p_pw[k] * 4) begin
          m_phase[k] = 2;
        end else if (m_streak[k] >= p_hr[k]) begin
          m_phase[k] = 2;
        end else if (m_cnt[k] == p_max[k]) begin
          m_to[k]    = 1'b1;
          m_phase[k] = p_tif[k] ? 3 : 2;
        end
      end
      default: ;
    endcase
  endfunction

  // {done, pass, fail, timeout, count[7:0], fail_pc, fail_data}
  function automatic logic [75:0] exp_vec(int k);
    return {m_phase[k] >= 2, m_phase[k] == 2, m_phase[k] == 3, m_to[k], 8'(m_cnt[k]),
            m_fpc[k], m_fdata[k]};
  endfunction

  function automatic logic [75:0] dut_vec(int k);
    if (k == 0)
      return {if0.done, if0.pass, if0.fail, if0.timeout, 8'(if0.cycle_count), if0.fail_pc,
              if0.fail_data};
    return {if1.done, if1.pass, if1.fail, if1.timeout, 8'(if1.cycle_count), if1.fail_pc,
            if1.fail_data};
  endfunction

  // Drive one bus cycle to both monitors, advance the model, settle past the edge.
  task automatic step(input logic en, input logic [31:0] p, input logic we,
                      input logic [4:0] a, input logic [31:0] d);
    if0.enable = en; if0.pc = p; if0.rd_we = we; if0.rd_addr = a; if0.rd_wdata = d;
    if1.enable = en; if1.pc = p; if1.rd_we = we; if1.rd_addr = a; if1.rd_wdata = d;
    @(posedge clk);
    model_edge(0, en, p, we, a, d);
    model_edge(1, en, p, we, a, d);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    model_clear(0);
    model_clear(1);
    #3;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (dut_vec(k) !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL reset inst%0d: got %h want %h", k, dut_vec(k), exp_vec(k));
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_clean_run;
    step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 32'(i * 4), 1'b1, 5'd31, 32'h0);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (dut_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL clean_run inst%0d edge %0d: got %h want %h", k, i + 1, dut_vec(k),
                   exp_vec(k));
        end
      end
    end
    vectors++;
    if ({if0.done, if0.pass, if0.timeout, if0.cycle_count} !== {3'b111, 6'd32}) begin
      miscompares++;
      $display("FAIL clean_run_verdict: got done/pass/to=%b%b%b cnt=%0d want 111 cnt=32",
               if0.done, if0.pass, if0.timeout, if0.cycle_count);
    end
  endtask

  task automatic test_violation;
    step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b1, 5'd31, 32'h0);
    step(1'b1, 32'h10, 1'b1, 5'd31, 32'h5);
    vectors++;
    if ({if0.fail, if0.fail_pc, if0.fail_data, if0.cycle_count} !== {1'b1, 32'h10, 32'h5, 6'd5})
    begin
      miscompares++;
      $display("FAIL violation: got fail=%b pc=%h data=%h cnt=%0d want 1 00000010 00000005 5",
               if0.fail, if0.fail_pc, if0.fail_data, if0.cycle_count);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 32'h14 + 32'(i * 4), 1'b1, 5'd31, 32'h99 + 32'(i));
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (dut_vec(k) !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL violation_sticky inst%0d: got %h want %h", k, dut_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_halt;
    logic [31:0] pcs [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC};
    step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, pcs[i], 1'b1, 5'd3, 32'h1234);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (dut_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL halt inst%0d edge %0d: got %h want %h", k, i + 1, dut_vec(k),
                   exp_vec(k));
        end
      end
    end
    vectors++;
    if ({if0.pass, if0.timeout, if0.cycle_count} !== {2'b10, 6'd6}) begin
      miscompares++;
      $display("FAIL halt_verdict: got pass/to=%b%b cnt=%0d want 10 cnt=6",
               if0.pass, if0.timeout, if0.cycle_count);
    end
  endtask

  task automatic test_out_of_range;
    for (int pass_n = 0; pass_n < 2; pass_n++) begin
      step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
      step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
      step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
      step(1'b1, 32'h4, 1'b0, 5'd0, 32'h0);
      step(1'b1, 32'h80, pass_n[0], 5'd31, 32'h7);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (dut_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL out_of_range%0d inst%0d: got %h want %h", pass_n, k, dut_vec(k),
                   exp_vec(k));
        end
      end
      vectors++;
      if (pass_n == 0 && {if0.pass, if0.fail} !== 2'b10) begin
        miscompares++;
        $display("FAIL oor_pass: got pass/fail=%b%b want 10", if0.pass, if0.fail);
      end else if (pass_n == 1 && {if0.pass, if0.fail, if0.fail_data} !== {2'b01, 32'h7}) begin
        miscompares++;
        $display("FAIL oor_violation: got pass/fail=%b%b data=%h want 01 00000007",
                 if0.pass, if0.fail, if0.fail_data);
      end
    end
  endtask

  task automatic test_timeout_fail;
    step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b1, 5'd5, 32'hA5);
    vectors++;
    if ({if1.fail, if1.pass, if1.timeout, if1.cycle_count} !== {3'b101, 3'd4}) begin
      miscompares++;
      $display("FAIL timeout_fail: got fail/pass/to=%b%b%b cnt=%0d want 101 cnt=4",
               if1.fail, if1.pass, if1.timeout, if1.cycle_count);
    end
  endtask

  task automatic test_async_reset;
    step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h4, 1'b1, 5'd5, 32'h1);
    #2;
    reset = 1'b0;
    model_clear(0);
    model_clear(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (dut_vec(k) !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL async_reset inst%0d: got %h want %h", k, dut_vec(k), exp_vec(k));
      end
    end
    #1;
    reset = 1'b1;
  endtask

  task automatic test_enable_drop;
    step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0, 1'b1, 5'd31, 32'h3);
    step(1'b0, 32'h4, 1'b0, 5'd0, 32'h0);
    vectors++;
    if ({if0.done, if0.fail, if0.fail_data} !== {2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL enable_drop: got done/fail=%b%b data=%h want 00 00000000",
               if0.done, if0.fail, if0.fail_data);
    end
    step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
    vectors++;
    if ({if0.done, if0.cycle_count} !== {1'b0, 6'd1}) begin
      miscompares++;
      $display("FAIL enable_rerun: got done=%b cnt=%0d want 0 cnt=1", if0.done,
               if0.cycle_count);
    end
  endtask

  task automatic test_random;
    logic [31:0] pc;
    logic        en;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    pc = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(63) != 0);
      if (m_phase[0] >= 2 && m_phase[1] >= 2 && $urandom_range(3) == 0) en = 1'b0;
      case ($urandom_range(15))
        11, 12, 15: ;
        13:         pc = 32'($urandom_range(40)) * 4;
        14:         pc = $urandom;
        default:    pc = pc + 32'h4;
      endcase
      if (!en) pc = 32'h0;
      we = 1'($urandom_range(1));
      case ($urandom_range(7))
        0:       a = 5'd0;
        1, 3:    a = 5'd31;
        2, 4:    a = 5'd5;
        default: a = 5'($urandom);
      endcase
      case ($urandom_range(7))
        2:       d = $urandom;
        3, 4, 0: d = 32'h0;
        default: d = 32'hA5;
      endcase
      step(en, pc, we, a, d);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (dut_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL random inst%0d step %0d: got %h want %h", k, i, dut_vec(k),
                   exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    if0.enable = 1'b0; if0.pc = '0; if0.rd_we = 1'b0; if0.rd_addr = '0; if0.rd_wdata = '0;
    if1.enable = 1'b0; if1.pc = '0; if1.rd_we = 1'b0; if1.rd_addr = '0; if1.rd_wdata = '0;
    test_reset;
    test_clean_run;
    test_violation;
    test_halt;
    test_out_of_range;
    test_timeout_fail;
    test_async_reset;
    test_enable_drop;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
